// File: rtl/in_debouncer_pkg.sv
// Shared defaults and helpers for the in_debouncer input-conditioning block.
package in_debounce_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int CHANGE_CNT_W        = 8;

   // Counter width for a window of n cycles; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/in_debouncer_debounce_cell.sv
// One debounced input bit: synchroniser chain, mismatch counter, clean level
// register and registered rise/fall pulses.
module debounce_cell
   import in_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw_in,
   input  logic enable,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;

   assign sync_q = sync_r[SYNC_STAGES-1];

   // A match always clears the count, even while frozen, so short glitches vanish.
   always_comb begin
      cnt_nxt = cnt;
      accept  = 1'b0;
      if (sync_q == clean) begin
         cnt_nxt = '0;
      end else if (enable) begin
         if (cnt == CNT_LAST) begin
            accept  = 1'b1;
            cnt_nxt = '0;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_r <= '0;
         cnt    <= '0;
         clean  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
         cnt    <= cnt_nxt;
         if (accept) begin
            clean <= sync_q;
         end
         rise   <= accept & sync_q;
         fall   <= accept & ~sync_q;
      end
   end

endmodule

// File: rtl/in_debouncer.sv
// Debounces WIDTH asynchronous inputs independently and keeps a wrapping
// count of every accepted transition.
module in_debouncer
   import in_debounce_pkg::*;
#(
   parameter int WIDTH           = 5,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [WIDTH-1:0]        RAW_IN,
   input  logic                    ENABLE,
   output logic [WIDTH-1:0]        CLEAN_OUT,
   output logic [WIDTH-1:0]        RISE,
   output logic [WIDTH-1:0]        FALL,
   output logic [CHANGE_CNT_W-1:0] CHANGE_CNT
);

   logic [WIDTH-1:0]        accept;
   logic [CHANGE_CNT_W-1:0] accept_cnt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      debounce_cell #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .CLK    (CLK),
         .RST    (RST),
         .raw_in (RAW_IN[i]),
         .enable (ENABLE),
         .clean  (CLEAN_OUT[i]),
         .rise   (RISE[i]),
         .fall   (FALL[i]),
         .accept (accept[i])
      );
   end

   // Uses the pre-register accept strobes so the count moves on the pulse edge.
   always_comb begin
      accept_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept_cnt = accept_cnt + CHANGE_CNT_W'(accept[i]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CHANGE_CNT <= '0;
      end else begin
         CHANGE_CNT <= CHANGE_CNT + accept_cnt;
      end
   end

endmodule
